prog_loader: RTL and testbench

Upstream fetch stage that feeds the CPU its instruction stream. It holds an internal instruction ROM image, filled at boot from a byte-serial link using a framed, checksummed protocol. It keeps the CPU in reset until a valid image has been loaded. Once loaded, it serves `instruct` combinationally from the CPU's `pc`, so the CPU stays single-cycle.

---
 rtl/prog_loader.sv | 125 ++++++++++++
 tb/tb_prog_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Boot-time instruction loader: receives a framed, checksummed image over a byte link,
// holds the CPU in reset until the image is good, then serves instructions from pc.
module prog_loader #(
  parameter int ADDR_W = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  input  logic [15:0] pc,
  output logic [15:0] instruct,
  output logic        cpu_rst,
  output logic        loading,
  output logic        error,
  output logic [15:0] words_loaded
);

  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, CHECK, RUN, ERR
  } state_t;

  localparam logic [16:0] DEPTH = 17'(2 ** ADDR_W);

  state_t            state, state_next;
  logic [7:0]        len_hi, data_hi, data_lo, chk_xor;
  logic [15:0]       len;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       mem [2 ** ADDR_W];
  logic              accept, hdr;
  logic [16:0]       len_req;
  logic [15:0]       words_next;

  assign rx_ready   = reset && (state != WRITE);
  assign accept     = rx_valid && rx_ready;
  assign hdr        = accept && (rx_data == 8'hA5) &&
                      (state == IDLE || state == RUN || state == ERR);
  assign len_req    = {1'b0, len_hi, rx_data};
  assign words_next = words_loaded + 16'd1;
  assign instruct   = mem[pc[ADDR_W-1:0]];

  generate
    if (ADDR_W < 16) begin : g_pc_hi
      logic unused_pc_hi;
      assign unused_pc_hi = ^pc[15:ADDR_W];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    cpu_rst    = (state != RUN);
    error      = (state == ERR);
    loading    = (state == LEN_HI) || (state == LEN_LO) || (state == DATA_HI) ||
                 (state == DATA_LO) || (state == WRITE) || (state == CHECK);
    case (state)
      IDLE, RUN, ERR: if (hdr) state_next = LEN_HI;
      LEN_HI:  if (accept) state_next = LEN_LO;
      LEN_LO: begin
        // Length is checked against the full memory depth in 17 bits so that
        // ADDR_W=16 never overflows the comparison.
        if (accept) begin
          if (len_req > DEPTH)       state_next = ERR;
          else if (len_req == 17'd0) state_next = CHECK;
          else                       state_next = DATA_HI;
        end
      end
      DATA_HI: if (accept) state_next = DATA_LO;
      DATA_LO: if (accept) state_next = WRITE;
      WRITE:   state_next = (words_next == len) ? CHECK : DATA_HI;
      CHECK:   if (accept) state_next = (rx_data == chk_xor) ? RUN : ERR;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_hi       <= '0;
      len          <= '0;
      data_hi      <= '0;
      data_lo      <= '0;
      chk_xor      <= '0;
      wr_addr      <= '0;
      words_loaded <= '0;
    end else if (hdr) begin
      chk_xor      <= '0;
      wr_addr      <= '0;
      words_loaded <= '0;
    end else begin
      case (state)
        LEN_HI: if (accept) begin
          len_hi  <= rx_data;
          chk_xor <= chk_xor ^ rx_data;
        end
        LEN_LO: if (accept) begin
          len     <= {len_hi, rx_data};
          chk_xor <= chk_xor ^ rx_data;
        end
        DATA_HI: if (accept) begin
          data_hi <= rx_data;
          chk_xor <= chk_xor ^ rx_data;
        end
        DATA_LO: if (accept) begin
          data_lo <= rx_data;
          chk_xor <= chk_xor ^ rx_data;
        end
        WRITE: begin
          wr_addr      <= wr_addr + 1'b1;
          words_loaded <= words_next;
        end
        default: ;
      endcase
    end
  end

  // Image memory has no reset so aborted loads leave earlier words in place.
  always_ff @(posedge clk) begin
    if (state == WRITE) mem[wr_addr] <= {data_hi, data_lo};
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: table of byte vectors with expected status outputs,
// plus hand-written back-pressure, oversize-length and asynchronous-reset sequences.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] pc;
  logic [15:0] instruct;
  logic        cpu_rst;
  logic        loading;
  logic        error;
  logic [15:0] words_loaded;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [7:0]  data;
    logic        valid;
    logic        exp_cpu_rst;
    logic        exp_loading;
    logic        exp_error;
    logic        exp_ready;
    logic [15:0] exp_words;
  } vec_t;

  vec_t vecs[$];

  prog_loader #(.ADDR_W(4)) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .pc(pc),
    .instruct(instruct),
    .cpu_rst(cpu_rst),
    .loading(loading),
    .error(error),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic c, input logic l,
                          input logic e, input logic r, input logic [15:0] w);
    checkOutput({tag, ".cpu_rst"}, {15'd0, cpu_rst}, {15'd0, c});
    checkOutput({tag, ".loading"}, {15'd0, loading}, {15'd0, l});
    checkOutput({tag, ".error"}, {15'd0, error}, {15'd0, e});
    checkOutput({tag, ".rx_ready"}, {15'd0, rx_ready}, {15'd0, r});
    checkOutput({tag, ".words_loaded"}, words_loaded, w);
  endtask

  task automatic checkMem(input string tag, input logic [15:0] addr,
                          input logic [15:0] expected);
    pc = addr;
    #1;
    checkOutput(tag, instruct, expected);
  endtask

  task automatic applyStimulus(input logic [7:0] d, input logic v);
    @(negedge clk);
    rx_data  = d;
    rx_valid = v;
    @(posedge clk);
    #1;
  endtask

  // Presents a byte with rx_valid held high until the loader takes it.
  task automatic sendHold(input logic [7:0] d, output int stalls);
    @(negedge clk);
    rx_data  = d;
    rx_valid = 1'b1;
    stalls   = 0;
    while (!rx_ready && stalls < 8) begin
      stalls++;
      @(negedge clk);
    end
    if (!rx_ready) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL accept_timeout: byte %h not accepted, ready=%b", d, rx_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic [7:0] d, input logic v, input logic c, input logic l,
                        input logic e, input logic r, input logic [15:0] w);
    vecs.push_back('{d, v, c, l, e, r, w});
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [7:0] bp_bytes [10];
    logic [7:0] nom_bytes [8];
    logic [9:0] stall_mask;
    int stalls, total_stalls;

    // Zero length with leading garbage from IDLE, plus idle/garbage in RUN
    addVec(8'h3C, 1, 1, 0, 0, 1, 0);
    addVec(8'hFF, 1, 1, 0, 0, 1, 0);
    addVec(8'hA5, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 0, 0, 0, 1, 0);
    addVec(8'h00, 0, 0, 0, 0, 1, 0);
    addVec(8'h3C, 1, 0, 0, 0, 1, 0);
    // Nominal two-word reload from RUN
    addVec(8'hA5, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h02, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h07, 1, 1, 1, 0, 0, 0);
    addVec(8'h00, 0, 1, 1, 0, 1, 1);
    addVec(8'hEC, 1, 1, 1, 0, 1, 1);
    addVec(8'h10, 1, 1, 1, 0, 0, 1);
    addVec(8'h00, 0, 1, 1, 0, 1, 2);
    addVec(8'hF9, 1, 0, 0, 0, 1, 2);
    // Bad checksum
    addVec(8'hA5, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h02, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h07, 1, 1, 1, 0, 0, 0);
    addVec(8'h00, 0, 1, 1, 0, 1, 1);
    addVec(8'hEC, 1, 1, 1, 0, 1, 1);
    addVec(8'h10, 1, 1, 1, 0, 0, 1);
    addVec(8'h00, 0, 1, 1, 0, 1, 2);
    addVec(8'hF8, 1, 1, 0, 1, 1, 2);
    addVec(8'h00, 0, 1, 0, 1, 1, 2);
    addVec(8'h3C, 1, 1, 0, 1, 1, 2);
    // Resend from ERR with junk offered during WRITE cycles
    addVec(8'hA5, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h02, 1, 1, 1, 0, 1, 0);
    addVec(8'h00, 1, 1, 1, 0, 1, 0);
    addVec(8'h07, 1, 1, 1, 0, 0, 0);
    addVec(8'hFF, 1, 1, 1, 0, 1, 1);
    addVec(8'hEC, 1, 1, 1, 0, 1, 1);
    addVec(8'h10, 1, 1, 1, 0, 0, 1);
    addVec(8'hFF, 1, 1, 1, 0, 1, 2);
    addVec(8'hF9, 1, 0, 0, 0, 1, 2);

    bp_bytes  = '{8'hA5, 8'h00, 8'h03, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2D};
    nom_bytes = '{8'hA5, 8'h00, 8'h02, 8'h00, 8'h07, 8'hEC, 8'h10, 8'hF9};

    reset    = 1'b0;
    rx_data  = 8'h00;
    rx_valid = 1'b0;
    pc       = 16'h0000;
    #1;
    checkAll("reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkAll("idle", 1, 0, 0, 1, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].data, vecs[i].valid);
      checkAll($sformatf("vec%0d", i), vecs[i].exp_cpu_rst, vecs[i].exp_loading,
               vecs[i].exp_error, vecs[i].exp_ready, vecs[i].exp_words);
    end
    rx_valid = 1'b0;
    checkMem("nominal.mem0", 16'h0000, 16'h0007);
    checkMem("nominal.mem1", 16'h0001, 16'hEC10);
    checkMem("nominal.pc_high_ignored", 16'hFFF1, 16'hEC10);

    // Back-pressure: rx_valid held high through a three-word frame
    stall_mask   = '0;
    total_stalls = 0;
    for (int i = 0; i < 10; i++) begin
      sendHold(bp_bytes[i], stalls);
      stall_mask[i] = (stalls > 0);
      total_stalls += stalls;
    end
    rx_valid = 1'b0;
    checkOutput("bp.stall_mask", {6'd0, stall_mask}, 16'h02A0);
    checkOutput("bp.total_stalls", 16'(total_stalls), 16'd3);
    checkAll("bp.run", 0, 0, 0, 1, 3);
    checkMem("bp.mem0", 16'h0000, 16'h1234);
    checkMem("bp.mem1", 16'h0001, 16'h5678);
    checkMem("bp.mem2", 16'h0002, 16'h9ABC);

    // Oversize length 17 with a 16-word memory
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h11, 1);
    checkAll("oversize", 1, 0, 1, 1, 0);
    applyStimulus(8'h00, 0);
    checkAll("oversize.hold", 1, 0, 1, 1, 0);
    checkMem("oversize.mem0", 16'h0000, 16'h1234);
    checkMem("oversize.mem1", 16'h0001, 16'h5678);

    // Length exactly equal to depth is accepted; one word then async reset
    applyStimulus(8'hA5, 1);
    applyStimulus(8'h00, 1);
    applyStimulus(8'h10, 1);
    checkAll("len16", 1, 1, 0, 1, 0);
    applyStimulus(8'hAA, 1);
    applyStimulus(8'hBB, 1);
    applyStimulus(8'h00, 0);
    checkAll("len16.word1", 1, 1, 0, 1, 1);
    checkMem("raw.mem0", 16'h0000, 16'hAABB);
    checkMem("raw.mem1", 16'h0001, 16'h5678);

    @(negedge clk);
    rx_data  = 8'hA5;
    rx_valid = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checkAll("async_reset", 1, 0, 0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    checkAll("async_reset.hold", 1, 0, 0, 0, 0);
    rx_valid = 1'b0;
    reset    = 1'b1;
    #1;
    checkAll("post_reset.idle", 1, 0, 0, 1, 0);

    for (int i = 0; i < 8; i++) sendHold(nom_bytes[i], stalls);
    rx_valid = 1'b0;
    checkAll("reload.run", 0, 0, 0, 1, 2);
    checkMem("reload.mem0", 16'h0000, 16'h0007);
    checkMem("reload.mem1", 16'h0001, 16'hEC10);
    checkMem("reload.mem2", 16'h0002, 16'h9ABC);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
